// File: rtl/axi4lite_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_cfg_pkg
// Description : Shared response codes, channel state encodings and helpers
//               for the AXI4-Lite configuration register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_cfg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_strb_reg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_strb_reg
// Description : One configuration register with per-byte write enables and
//               asynchronous reset to a fixed value.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_strb_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH/8-1:0] i_byte_en,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= RST_VAL;
        end else begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_byte_en[b]) begin
                    o_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_cfg_regbank.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_cfg_regbank
// Description : AXI4-Lite slave exposing NUM_RW strobed config registers with
//               write pulses and NUM_RO read-only status registers.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_cfg_regbank
    import axi4lite_cfg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NUM_RW     = 8,
    parameter int                    NUM_RO     = 4,
    parameter logic [DATA_WIDTH-1:0] RW_RST_VAL = '0
) (
    input  logic                                          ACLK,
    input  logic                                          ARESET,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_AWADDR,
    input  logic [2:0]                                    S_AXI_AWPROT,
    input  logic                                          S_AXI_AWVALID,
    output logic                                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                         S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                       S_AXI_WSTRB,
    input  logic                                          S_AXI_WVALID,
    output logic                                          S_AXI_WREADY,
    output logic [1:0]                                    S_AXI_BRESP,
    output logic                                          S_AXI_BVALID,
    input  logic                                          S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                         S_AXI_ARADDR,
    input  logic [2:0]                                    S_AXI_ARPROT,
    input  logic                                          S_AXI_ARVALID,
    output logic                                          S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                         S_AXI_RDATA,
    output logic [1:0]                                    S_AXI_RRESP,
    output logic                                          S_AXI_RVALID,
    input  logic                                          S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0]                  cfg_regs_o,
    output logic [NUM_RW-1:0]                             cfg_wr_pulse_o,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] sts_regs_i
);

    localparam int c_STRB_W   = DATA_WIDTH / 8;
    localparam int c_ADDR_LSB = clog2(c_STRB_W);

    wr_state_t               r_wr_state;
    rd_state_t               r_rd_state;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]     r_wstrb;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_arready;
    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [NUM_RW-1:0]       r_wr_pulse;

    logic [DATA_WIDTH-1:0]   w_cfg [NUM_RW];
    logic [31:0]             w_wr_idx;
    logic [31:0]             w_rd_idx;
    logic                    w_wr_is_rw;
    logic                    w_commit;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic [1:0]              w_rd_resp;
    logic                    w_unused_prot;

    assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign w_wr_idx   = 32'(r_awaddr >> c_ADDR_LSB);
    assign w_rd_idx   = 32'(S_AXI_ARADDR >> c_ADDR_LSB);
    assign w_wr_is_rw = (w_wr_idx < 32'(NUM_RW));
    assign w_aw_hs    = S_AXI_AWVALID && r_awready;
    assign w_w_hs     = S_AXI_WVALID && r_wready;
    assign w_ar_hs    = S_AXI_ARVALID && r_arready;
    // Commit happens on the edge that raises BVALID, one cycle after both halves land.
    assign w_commit   = (r_wr_state == W_RESP) && !r_bvalid;

    for (genvar k = 0; k < NUM_RW; k++) begin : g_cfg_reg
        logic [c_STRB_W-1:0] w_byte_en;
        assign w_byte_en = (w_commit && (w_wr_idx == 32'(k))) ? r_wstrb : '0;

        cfg_strb_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .RST_VAL    (RW_RST_VAL)
        ) u_reg (
            .clk       (ACLK),
            .rst       (ARESET),
            .i_byte_en (w_byte_en),
            .i_wdata   (r_wdata),
            .o_q       (w_cfg[k])
        );

        assign cfg_regs_o[k*DATA_WIDTH +: DATA_WIDTH] = w_cfg[k];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_state <= W_IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wr_state <= W_RESP;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_wr_state <= W_HAVE_AW;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wr_state <= W_HAVE_W;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b0;
                    end else begin
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_w_hs) begin
                        r_wr_state <= W_RESP;
                        r_wready   <= 1'b0;
                    end
                end
                W_HAVE_W: begin
                    if (w_aw_hs) begin
                        r_wr_state <= W_RESP;
                        r_awready  <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (!r_bvalid) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_is_rw ? RESP_OKAY : RESP_SLVERR;
                    end else if (S_AXI_BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= W_IDLE;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_pulse <= '0;
        end else begin
            for (int k = 0; k < NUM_RW; k++) begin
                r_wr_pulse[k] <= w_commit && (w_wr_idx == 32'(k));
            end
        end
    end

    // Read mux: RW regs show their pre-commit value; status is sampled live.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            if (w_rd_idx == 32'(k)) begin
                w_rd_data = w_cfg[k];
                w_rd_resp = RESP_OKAY;
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (w_rd_idx == 32'(NUM_RW + k)) begin
                w_rd_data = sts_regs_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_state <= R_RESP;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_resp;
                    end else begin
                        r_arready  <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_rd_state <= R_IDLE;
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign S_AXI_AWREADY  = r_awready;
    assign S_AXI_WREADY   = r_wready;
    assign S_AXI_BVALID   = r_bvalid;
    assign S_AXI_BRESP    = r_bresp;
    assign S_AXI_ARREADY  = r_arready;
    assign S_AXI_RVALID   = r_rvalid;
    assign S_AXI_RRESP    = r_rresp;
    assign S_AXI_RDATA    = r_rdata;
    assign cfg_wr_pulse_o = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_cfg_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_cfg_regbank
// Description : Directed scoreboard bench for the AXI4-Lite config reg bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_cfg_regbank;
    import axi4lite_cfg_pkg::*;

    localparam int          DW  = 32;
    localparam int          AW  = 8;
    localparam int          NRW = 8;
    localparam int          NRO = 4;
    localparam logic [31:0] RST = 32'h5A5A_0F0F;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [AW-1:0]     S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA;
    logic [DW/8-1:0]   S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [AW-1:0]     S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;
    logic [NRW*DW-1:0] cfg_regs_o;
    logic [NRW-1:0]    cfg_wr_pulse_o;
    logic [NRO*DW-1:0] sts_regs_i;

    axi4lite_cfg_regbank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RW     (NRW),
        .NUM_RO     (NRO),
        .RW_RST_VAL (RST)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .S_AXI_AWADDR   (S_AXI_AWADDR),
        .S_AXI_AWPROT   (S_AXI_AWPROT),
        .S_AXI_AWVALID  (S_AXI_AWVALID),
        .S_AXI_AWREADY  (S_AXI_AWREADY),
        .S_AXI_WDATA    (S_AXI_WDATA),
        .S_AXI_WSTRB    (S_AXI_WSTRB),
        .S_AXI_WVALID   (S_AXI_WVALID),
        .S_AXI_WREADY   (S_AXI_WREADY),
        .S_AXI_BRESP    (S_AXI_BRESP),
        .S_AXI_BVALID   (S_AXI_BVALID),
        .S_AXI_BREADY   (S_AXI_BREADY),
        .S_AXI_ARADDR   (S_AXI_ARADDR),
        .S_AXI_ARPROT   (S_AXI_ARPROT),
        .S_AXI_ARVALID  (S_AXI_ARVALID),
        .S_AXI_ARREADY  (S_AXI_ARREADY),
        .S_AXI_RDATA    (S_AXI_RDATA),
        .S_AXI_RRESP    (S_AXI_RRESP),
        .S_AXI_RVALID   (S_AXI_RVALID),
        .S_AXI_RREADY   (S_AXI_RREADY),
        .cfg_regs_o     (cfg_regs_o),
        .cfg_wr_pulse_o (cfg_wr_pulse_o),
        .sts_regs_i     (sts_regs_i)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [1:0]     resp;
        logic [NRW-1:0] pulse;
    } bexp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_cfg [NRW];
    bexp_t       b_q [$];
    rexp_t       r_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_cfg(input string tag);
        for (int k = 0; k < NRW; k++) begin
            chk(tag, cfg_regs_o[k*DW +: DW], m_cfg[k]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NRW; k++) begin
            m_cfg[k] = RST;
        end
        b_q.delete();
        r_q.delete();
    endtask

    task automatic wr_issue(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_delay);
        bexp_t e;
        int    idx;
        bit    aw_p, w_p, aw_f, w_f;
        idx     = int'(addr >> 2);
        e.pulse = '0;
        e.resp  = (idx < NRW) ? RESP_OKAY : RESP_SLVERR;
        if (idx < NRW) begin
            e.pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m_cfg[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        b_q.push_back(e);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        S_AXI_AWVALID = 1'b0;
        aw_p = 1'b1;
        w_p  = 1'b1;
        for (int c = 0; c < 30 && (aw_p || w_p); c++) begin
            if (aw_p && c >= aw_delay) S_AXI_AWVALID = 1'b1;
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            if (aw_f) begin aw_p = 1'b0; S_AXI_AWVALID = 1'b0; end
            if (w_f)  begin w_p  = 1'b0; S_AXI_WVALID  = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("wr_handshake_pending", {aw_p, w_p}, 0);
    endtask

    task automatic wr_resp(output int lat);
        bexp_t e;
        lat = 0;
        while (!S_AXI_BVALID && lat < 20) begin
            step();
            lat++;
        end
        e = (b_q.size() > 0) ? b_q.pop_front() : '0;
        chk("bvalid", S_AXI_BVALID, 1);
        chk("bresp", S_AXI_BRESP, e.resp);
        chk("wr_pulse", cfg_wr_pulse_o, e.pulse);
    endtask

    task automatic wr_done();
        step();
        chk("bvalid_clear", S_AXI_BVALID, 0);
        chk("wr_pulse_clear", cfg_wr_pulse_o, 0);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int lat;
        wr_issue(addr, data, strb, 0);
        wr_resp(lat);
        wr_done();
    endtask

    task automatic rd_issue(input logic [7:0] addr);
        rexp_t e;
        int    idx;
        bit    pend, f;
        idx = int'(addr >> 2);
        if (idx < NRW) begin
            e.data = m_cfg[idx];
            e.resp = RESP_OKAY;
        end else if (idx < NRW + NRO) begin
            e.data = sts_regs_i[(idx-NRW)*DW +: DW];
            e.resp = RESP_OKAY;
        end else begin
            e.data = '0;
            e.resp = RESP_SLVERR;
        end
        r_q.push_back(e);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        pend = 1'b1;
        for (int c = 0; c < 30 && pend; c++) begin
            f = S_AXI_ARVALID && S_AXI_ARREADY;
            step();
            if (f) pend = 1'b0;
        end
        S_AXI_ARVALID = 1'b0;
        chk("rd_handshake_pending", pend, 0);
    endtask

    task automatic rd_resp();
        rexp_t e;
        int    lat;
        lat = 0;
        while (!S_AXI_RVALID && lat < 20) begin
            step();
            lat++;
        end
        e = (r_q.size() > 0) ? r_q.pop_front() : '0;
        chk("rvalid", S_AXI_RVALID, 1);
        chk("rdata", S_AXI_RDATA, e.data);
        chk("rresp", S_AXI_RRESP, e.resp);
    endtask

    task automatic rd(input logic [7:0] addr);
        rd_issue(addr);
        rd_resp();
        step();
        chk("rvalid_clear", S_AXI_RVALID, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = 3'b000;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = 3'b000;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        sts_regs_i    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        model_reset();

        // Reset held for 200 ns; outputs checked mid-reset.
        #100;
        chk("rst_awready", S_AXI_AWREADY, 0);
        chk("rst_wready", S_AXI_WREADY, 0);
        chk("rst_arready", S_AXI_ARREADY, 0);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_bresp", S_AXI_BRESP, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_pulse", cfg_wr_pulse_o, 0);
        check_cfg("rst_cfg");
        #100;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        step();
        step();
        chk("idle_awready", S_AXI_AWREADY, 1);
        chk("idle_arready", S_AXI_ARREADY, 1);

        // Basic writes and read-back.
        for (int i = 0; i < 4; i++) begin
            wr(8'(i*4), 32'(i+1), 4'hF);
        end
        for (int i = 0; i < 4; i++) begin
            rd(8'(i*4));
        end
        check_cfg("cfg_after_basic");

        // W leads AW by three cycles.
        wr_issue(8'h04, 32'hA5A5_A5A5, 4'hF, 3);
        wr_resp(lat);
        chk("late_aw_bvalid_latency", lat, 1);
        wr_done();
        rd(8'h04);

        // Byte strobes.
        wr(8'h08, 32'h1122_3344, 4'hF);
        wr(8'h08, 32'hFFFF_FFFF, 4'b0010);
        chk("strb_reg2", cfg_regs_o[2*DW +: DW], 32'h1122_FF44);
        rd(8'h08);

        // Zero strobe still pulses but leaves data alone.
        wr(8'h0C, 32'hFFFF_FFFF, 4'b0000);
        check_cfg("cfg_zero_strb");

        // RO and unmapped targets.
        wr(8'h20, 32'h0000_DEAD, 4'hF);
        wr(8'hFC, 32'h0000_DEAD, 4'hF);
        rd(8'hFC);
        check_cfg("cfg_after_slverr");

        // Status is sampled on the AR edge, later changes must not leak.
        rd_issue(8'h24);
        sts_regs_i[63:32] = 32'h0BAD_0BAD;
        rd_resp();
        step();
        rd(8'h24);

        // Back-pressure hold followed by reset mid-hold.
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        wr_issue(8'h14, 32'h1234_5678, 4'hF, 0);
        wr_resp(lat);
        rd_issue(8'h14);
        rd_resp();
        S_AXI_AWADDR  = 8'h18;
        S_AXI_WDATA   = 32'h0000_0077;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARADDR  = 8'h18;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_bvalid", S_AXI_BVALID, 1);
            chk("hold_bresp", S_AXI_BRESP, RESP_OKAY);
            chk("hold_rvalid", S_AXI_RVALID, 1);
            chk("hold_rdata", S_AXI_RDATA, 32'h1234_5678);
            chk("hold_awready", S_AXI_AWREADY, 0);
            chk("hold_wready", S_AXI_WREADY, 0);
            chk("hold_arready", S_AXI_ARREADY, 0);
        end
        ARESET = 1'b1;
        #1;
        chk("midrst_bvalid", S_AXI_BVALID, 0);
        chk("midrst_rvalid", S_AXI_RVALID, 0);
        chk("midrst_awready", S_AXI_AWREADY, 0);
        model_reset();
        check_cfg("midrst_cfg");
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b1;
        step();
        step();
        ARESET = 1'b0;
        step();
        step();
        chk("post_rst_bvalid", S_AXI_BVALID, 0);
        chk("post_rst_pulse", cfg_wr_pulse_o, 0);
        rd(8'h14);
        wr(8'h18, 32'h0000_600D, 4'hF);
        rd(8'h18);
        check_cfg("cfg_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
